// File: rtl/aes_wr_pkg.sv
// Shared types and constants for the AES result writer.
// The AES_WR_WRAP_EN macro (see aes_result_writer) selects wrap-around instead of stop-on-full.
package aes_wr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } wr_state_e;

  localparam int unsigned WORDS_PER_BLOCK = 4;
  localparam int unsigned BLOCK_WIDTH     = 128;
  localparam int unsigned WORD_WIDTH      = 32;
  localparam int unsigned WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);

endpackage

// File: rtl/aes_word_sel.sv
// Combinational 128->32 word selector; index 0 returns the most significant word.
module aes_word_sel
  import aes_wr_pkg::*;
(
  input  logic [BLOCK_WIDTH-1:0] blk_i,
  input  logic [WORD_IDX_W-1:0]  idx_i,
  output logic [WORD_WIDTH-1:0]  word_o
);

  always_comb begin
    case (idx_i)
      2'd0:    word_o = blk_i[127:96];
      2'd1:    word_o = blk_i[95:64];
      2'd2:    word_o = blk_i[63:32];
      default: word_o = blk_i[31:0];
    endcase
  end

endmodule

// File: rtl/aes_result_writer.sv
// Writes accepted 128-bit blocks to the output memory as four consecutive 32-bit words.
// Define AES_WR_WRAP_EN to wrap the address at the top of memory instead of stopping in FULL.
module aes_result_writer
  import aes_wr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   blk_valid_i,
  input  logic [BLOCK_WIDTH-1:0] blk_data_i,
  output logic                   blk_ready_o,
  output logic                   mem_we_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  output logic [DATA_WIDTH-1:0]  mem_wdata_o,
  output logic                   busy_o,
  output logic                   full_o,
  output logic [ADDR_WIDTH-2:0]  blk_count_o
);

  wr_state_e               state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [WORD_IDX_W-1:0]   word_idx_q, word_idx_d;
  logic [ADDR_WIDTH-2:0]   count_q, count_d;
  logic [BLOCK_WIDTH-1:0]  hold_q, hold_d;
  logic                    we_q, we_d;
  logic                    full_q, full_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [WORD_WIDTH-1:0]   sel_word;
  logic                    last_beat;
  logic                    ready;
  logic                    xfer;

  assign last_beat = (state_q == WRITE) && (word_idx_q == 2'd3);

`ifdef AES_WR_WRAP_EN
  assign ready = !start_i && ((state_q == IDLE) || last_beat);
`else
  logic last_slot;
  // The final block of memory may not be followed by a back-to-back transfer.
  assign last_slot = (wr_addr_q == {ADDR_WIDTH{1'b1}});
  assign ready     = !start_i && ((state_q == IDLE) || (last_beat && !last_slot));
`endif

  assign xfer = blk_valid_i && ready;

  // Selects from the next-cycle block and index so the data output can be registered.
  aes_word_sel u_word_sel (
    .blk_i  (hold_d),
    .idx_i  (word_idx_d),
    .word_o (sel_word)
  );

  always_comb begin
    // NOTE: every _d signal takes its hold value first so no branch can infer a latch.
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    word_idx_d = word_idx_q;
    count_d    = count_q;
    hold_d     = hold_q;

    if (start_i) begin
      state_d    = IDLE;
      wr_addr_d  = '0;
      word_idx_d = '0;
      count_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            state_d    = WRITE;
            word_idx_d = '0;
            hold_d     = blk_data_i;
          end
        end
        WRITE: begin
          wr_addr_d  = wr_addr_q + 1'b1;
          word_idx_d = word_idx_q + 1'b1;
          if (word_idx_q == 2'd3) begin
            count_d = count_q + 1'b1;
            if (xfer) begin
              hold_d = blk_data_i;
            end else begin
`ifdef AES_WR_WRAP_EN
              state_d = IDLE;
`else
              state_d = last_slot ? FULL : IDLE;
`endif
            end
          end
        end
`ifndef AES_WR_WRAP_EN
        FULL: state_d = FULL;
`endif
        default: state_d = IDLE;
      endcase
    end

    we_d    = (state_d == WRITE);
`ifdef AES_WR_WRAP_EN
    full_d  = 1'b0;
`else
    full_d  = (state_d == FULL);
`endif
    wdata_d = we_d ? sel_word : wdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      word_idx_q <= '0;
      count_q    <= '0;
      // NOTE: the holding register is reset as well, so no X can reach mem_wdata_o.
      hold_q     <= '0;
      we_q       <= 1'b0;
      full_q     <= 1'b0;
      wdata_q    <= '0;
    end else begin
      // NOTE: non-blocking so every register updates from the same pre-edge values.
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      word_idx_q <= word_idx_d;
      count_q    <= count_d;
      hold_q     <= hold_d;
      we_q       <= we_d;
      full_q     <= full_d;
      wdata_q    <= wdata_d;
    end
  end

  assign blk_ready_o = ready;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = wr_addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state_q == WRITE);
  assign full_o      = full_q;
  assign blk_count_o = count_q;

endmodule

// File: tb/tb_aes_result_writer.sv
// Self-checking bench for aes_result_writer at ADDR_WIDTH=4, against a schedule-based model.
module tb_aes_result_writer;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int CW    = AW - 1;
`ifdef AES_WR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_ni, start_i, blk_valid_i;
  logic [127:0]  blk_data_i;
  logic          blk_ready_o, mem_we_o, busy_o, full_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [CW-1:0] blk_count_o;

  always #5 clk = ~clk;

  aes_result_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .blk_valid_i (blk_valid_i),
    .blk_data_i  (blk_data_i),
    .blk_ready_o (blk_ready_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .busy_o      (busy_o),
    .full_o      (full_o),
    .blk_count_o (blk_count_o)
  );

  typedef struct packed {
    logic          ready;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          busy;
    logic          full;
    logic [CW-1:0] count;
  } snap_t;

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  snap_t       obs_q[$];
  snap_t       exp_q[$];
  wr_t         wq[$];     // scheduled memory writes, in cycle order
  int          cq[$];     // cycles at whose end the block count increments
  int          cyc;
  int          alloc;     // words assigned an address since reset/start
  int          busy_end;  // last beat cycle of the block being written
  logic [CW-1:0] m_count;
  logic [31:0] last_wdata;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_clear();
    wq.delete();
    cq.delete();
    alloc    = 0;
    busy_end = cyc;
    m_count  = '0;
  endtask

  // One clock cycle: predict outputs, sample DUT mid-cycle, then advance the model past the edge.
  task automatic step();
    snap_t e, o;
    bit    hs;
    e.ready = !start_i && (cyc >= busy_end) && (WRAP || alloc < DEPTH);
    e.we    = (wq.size() > 0) && (wq[0].c == cyc);
    e.addr  = e.we ? wq[0].a : '0;
    e.data  = e.we ? wq[0].d : last_wdata;
    e.busy  = e.we;
    e.full  = !WRAP && (alloc >= DEPTH) && (cyc > busy_end);
    e.count = m_count;
    @(negedge clk);
    o.ready = blk_ready_o;
    o.we    = mem_we_o;
    o.addr  = mem_we_o ? mem_addr_o : '0;
    o.data  = mem_wdata_o;
    o.busy  = busy_o;
    o.full  = full_o;
    o.count = blk_count_o;
    obs_q.push_back(o);
    exp_q.push_back(e);
    hs = blk_valid_i && e.ready;
    @(posedge clk);
    if (e.we) begin
      last_wdata = wq[0].d;
      void'(wq.pop_front());
    end
    if (cq.size() > 0 && cq[0] == cyc) begin
      m_count = m_count + 1'b1;
      void'(cq.pop_front());
    end
    if (start_i) begin
      model_clear();
    end else if (hs) begin
      for (int k = 0; k < 4; k++) begin
        wr_t w;
        w.c = cyc + 1 + k;
        w.a = AW'((alloc + k) % DEPTH);
        w.d = blk_data_i[127 - 32*k -: 32];
        wq.push_back(w);
      end
      cq.push_back(cyc + 4);
      alloc    = alloc + 4;
      busy_end = cyc + 4;
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; start_i = 1'b0; blk_valid_i = 1'b0; blk_data_i = '0;
    #2;
    n_checks += 7;
    if (blk_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", blk_ready_o); end
    if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", mem_we_o); end
    if (mem_addr_o !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", mem_addr_o); end
    if (mem_wdata_o !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", mem_wdata_o); end
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    if (full_o !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full_o); end
    if (blk_count_o !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", blk_count_o); end
    @(negedge clk) rst_ni = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    last_wdata = '0;
    model_clear();
  endtask

  task automatic test_single_block();
    blk_data_i  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    blk_valid_i = 1'b1;
    step();
    blk_valid_i = 1'b0;
    blk_data_i  = rand_blk();
    repeat (6) step();
    foreach (obs_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL single_block cycle %0d: got %p want %p", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
    n_checks++;
    if (blk_count_o !== 3'd1) begin n_fail++; $display("FAIL single_block_count: got %0d want 1", blk_count_o); end
  endtask

  task automatic test_back_to_back();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    blk_valid_i = 1'b1;
    for (int i = 0; i < 22; i++) begin
      blk_data_i = rand_blk();
      step();
    end
    blk_valid_i = 1'b0;
    repeat (4) step();
    foreach (obs_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got %p want %p", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
    n_checks += 2;
`ifdef AES_WR_WRAP_EN
    if (full_o !== 1'b0) begin n_fail++; $display("FAIL back_to_back_full: got %b want 0", full_o); end
    if (blk_count_o !== 3'd6) begin n_fail++; $display("FAIL back_to_back_count: got %0d want 6", blk_count_o); end
`else
    if (full_o !== 1'b1) begin n_fail++; $display("FAIL back_to_back_full: got %b want 1", full_o); end
    if (blk_count_o !== 3'd4) begin n_fail++; $display("FAIL back_to_back_count: got %0d want 4", blk_count_o); end
`endif
  endtask

  task automatic test_start_in_full();
    start_i = 1'b1;
    blk_valid_i = 1'b1;
    blk_data_i = rand_blk();
    step();
    start_i = 1'b0;
    blk_valid_i = 1'b0;
    #1;
    n_checks += 2;
    if (full_o !== 1'b0) begin n_fail++; $display("FAIL start_in_full_full: got %b want 0", full_o); end
    if (blk_ready_o !== 1'b1) begin n_fail++; $display("FAIL start_in_full_ready: got %b want 1", blk_ready_o); end
    step();
    blk_valid_i = 1'b1;
    blk_data_i = rand_blk();
    step();
    blk_valid_i = 1'b0;
    repeat (5) step();
    foreach (obs_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL start_in_full cycle %0d: got %p want %p", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_start_mid_block();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    blk_valid_i = 1'b1;
    blk_data_i = rand_blk();
    step();
    blk_data_i = rand_blk();
    repeat (4) step();
    blk_valid_i = 1'b0;
    repeat (2) step();
    start_i = 1'b1;          // word-2 beat of the second block
    step();
    start_i = 1'b0;
    step();
    blk_valid_i = 1'b1;
    blk_data_i = rand_blk();
    step();
    blk_valid_i = 1'b0;
    repeat (6) step();
    foreach (obs_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL start_mid_block cycle %0d: got %p want %p", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
    n_checks++;
    if (blk_count_o !== 3'd1) begin n_fail++; $display("FAIL start_mid_block_count: got %0d want 1", blk_count_o); end
  endtask

  task automatic test_random();
    start_i = 1'b1;
    step();
    for (int i = 0; i < 240; i++) begin
      blk_valid_i = ($urandom_range(0, 2) != 0);
      start_i     = ($urandom_range(0, 29) == 0);
      blk_data_i  = rand_blk();
      step();
    end
    blk_valid_i = 1'b0;
    start_i = 1'b0;
    repeat (6) step();
    foreach (obs_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %p want %p", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_async_reset();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    blk_valid_i = 1'b1;
    blk_data_i = rand_blk();
    step();
    blk_valid_i = 1'b0;
    repeat (2) step();
    #2 rst_ni = 1'b0;
    #1;
    n_checks += 3;
    if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL async_reset_we: got %b want 0", mem_we_o); end
    if (mem_addr_o !== '0) begin n_fail++; $display("FAIL async_reset_addr: got %0d want 0", mem_addr_o); end
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b want 0", busy_o); end
    @(negedge clk) rst_ni = 1'b1;
    @(posedge clk);
    #1;
    last_wdata = '0;
    model_clear();
    blk_valid_i = 1'b1;
    blk_data_i = rand_blk();
    step();
    blk_valid_i = 1'b0;
    repeat (6) step();
    foreach (obs_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL async_reset cycle %0d: got %p want %p", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_back_to_back();
    test_start_in_full();
    test_start_mid_block();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
